// File: rtl/video_scanout.sv
// 640x480@60 scanout of a 1bpp framebuffer playfield (64x32 lores / 128x64 hires) into a 512x256 window.
// Define SCANOUT_BORDER_EN to drive the border output; otherwise border is tied low.
module video_scanout (
  input  logic        clk,
  input  logic        reset,
  input  logic        hires,
  output logic [8:0]  buf_addr,
  output logic        buf_enable,
  input  logic [15:0] buf_out,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        pixel,
  output logic        border,
  output logic        vblank
);

  logic [9:0]  r_h, r_v;
  logic        r_hires;
  logic        r_buf_enable, r_rd_pend;
  logic [8:0]  r_buf_addr;
  logic [15:0] r_prefetch, r_shift;
  logic        r_p1_hsync, r_p1_vsync, r_p1_active, r_p1_win, r_p1_vblank;
  logic        r_hsync, r_vsync, r_active, r_pixel, r_vblank;

  logic        w_hwin, w_vwin, w_load, w_shift, w_fetch;
  logic [6:0]  w_hx;
  logic [8:0]  w_hr;
  logic [5:0]  w_vrow;
  logic [8:0]  w_addr;

  // Window position decode: w_hx is the offset into the window, w_hr the offset from the first fetch slot
  always_comb begin
    w_hx   = r_h[6:0] - 7'd64;
    w_hr   = r_h[8:0] - 9'd61;
    w_vrow = r_v[7:2] - 6'd28;
    w_hwin = (r_h >= 10'd64) && (r_h < 10'd576);
    w_vwin = (r_v >= 10'd112) && (r_v < 10'd368);
    if (r_hires) begin
      w_load  = w_vwin && w_hwin && (w_hx[5:0] == 6'd0);
      w_shift = w_vwin && w_hwin && (w_hx[1:0] == 2'd0);
      w_fetch = w_vwin && (r_h >= 10'd61) && (r_h <= 10'd572) && (w_hr[5:0] == 6'd0);
      w_addr  = {w_vrow, w_hr[8:6]};
    end else begin
      w_load  = w_vwin && w_hwin && (w_hx[6:0] == 7'd0);
      w_shift = w_vwin && w_hwin && (w_hx[2:0] == 3'd0);
      w_fetch = w_vwin && (r_h >= 10'd61) && (r_h <= 10'd572) && (w_hr[6:0] == 7'd0);
      w_addr  = {2'b00, w_vrow[5:1], w_hr[8:7]};
    end
  end

  // Raster counters and per-frame mode latch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h     <= 10'd0;
      r_v     <= 10'd0;
      r_hires <= 1'b0;
    end else begin
      if (r_h == 10'd799) begin
        r_h <= 10'd0;
        r_v <= (r_v == 10'd524) ? 10'd0 : r_v + 10'd1;
      end else begin
        r_h <= r_h + 10'd1;
      end
      if ((r_h == 10'd0) && (r_v == 10'd0)) r_hires <= hires;
    end
  end

  // Fetch one word ahead: read, capture into prefetch, then hand over at the word boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_enable <= 1'b0;
      r_buf_addr   <= 9'd0;
      r_rd_pend    <= 1'b0;
      r_prefetch   <= 16'h0000;
      r_shift      <= 16'h0000;
    end else begin
      r_buf_enable <= w_fetch;
      if (w_fetch) r_buf_addr <= w_addr;
      r_rd_pend <= r_buf_enable;
      if (r_rd_pend) r_prefetch <= buf_out;
      if (w_load) r_shift <= r_prefetch;
      else if (w_shift) r_shift <= {r_shift[14:0], 1'b0};
    end
  end

  // Two-stage timing pipeline; r_shift[15] lines up with stage 1
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p1_hsync  <= 1'b1;
      r_p1_vsync  <= 1'b1;
      r_p1_active <= 1'b0;
      r_p1_win    <= 1'b0;
      r_p1_vblank <= 1'b0;
      r_hsync     <= 1'b1;
      r_vsync     <= 1'b1;
      r_active    <= 1'b0;
      r_pixel     <= 1'b0;
      r_vblank    <= 1'b0;
    end else begin
      r_p1_hsync  <= !((r_h >= 10'd656) && (r_h < 10'd752));
      r_p1_vsync  <= !((r_v >= 10'd490) && (r_v < 10'd492));
      r_p1_active <= (r_h < 10'd640) && (r_v < 10'd480);
      r_p1_win    <= w_hwin && w_vwin;
      r_p1_vblank <= (r_h == 10'd0) && (r_v == 10'd480);
      r_hsync     <= r_p1_hsync;
      r_vsync     <= r_p1_vsync;
      r_active    <= r_p1_active;
      r_pixel     <= r_shift[15] & r_p1_win & r_p1_active;
      r_vblank    <= r_p1_vblank;
    end
  end

`ifdef SCANOUT_BORDER_EN
  logic r_border;

  // Border marks visible pixels outside the playfield
  always_ff @(posedge clk) begin
    if (reset) r_border <= 1'b0;
    else       r_border <= r_p1_active & ~r_p1_win;
  end
  assign border = r_border;
`else
  assign border = 1'b0;
`endif

  assign buf_enable = r_buf_enable;
  assign buf_addr   = r_buf_addr;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign active     = r_active;
  assign pixel      = r_pixel;
  assign vblank     = r_vblank;

endmodule

// File: tb/tb_video_scanout.sv
// Directed bench for video_scanout: hires frame with mid-frame toggle, mid-line reset, then lores frame with timing counts.
module tb_video_scanout;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hires = 1'b1;
  logic [8:0]  buf_addr;
  logic        buf_enable;
  logic [15:0] buf_out = 16'h0000;
  logic        hsync, vsync, active, pixel, border, vblank;

  logic [15:0] mem [0:511];
  int k = 0;
  int errors = 0;
  int checks = 0;
  int hs_low = 0, vs_low = 0, act_cnt = 0, vb_cnt = 0, vb_k = -1;
  bit cnt_en = 1'b0;
  localparam int K_END = 395002;

  always #20 clk = ~clk;

  video_scanout dut (
    .clk(clk), .reset(reset), .hires(hires),
    .buf_addr(buf_addr), .buf_enable(buf_enable), .buf_out(buf_out),
    .hsync(hsync), .vsync(vsync), .active(active), .pixel(pixel),
    .border(border), .vblank(vblank)
  );

  // Framebuffer read port: data one clock after the strobe
  always @(posedge clk) if (buf_enable) buf_out <= mem[buf_addr];

  // Clocks since reset release; the DUT counter position equals k
  always @(posedge clk) if (reset) k <= 0; else k <= k + 1;

  // Timing statistics over the post-reset frame
  always @(negedge clk) begin
    if (cnt_en && !reset && k >= 2 && k < K_END) begin
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (active) act_cnt++;
      if (vblank) begin vb_cnt++; vb_k = k; end
    end
  end

  task automatic chk(input string tag, input int x, input int y, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at (%0d,%0d): got %0h expected %0h", tag, x, y, obs, exp);
    end
  endtask

  function automatic logic exp_pix(int x, int y, bit hr);
    int sc, col, row, a;
    if (x < 64 || x > 575 || y < 112 || y > 367) return 1'b0;
    sc  = hr ? 4 : 8;
    col = (x - 64) / sc;
    row = (y - 112) / sc;
    a   = row * (hr ? 8 : 4) + col / 16;
    return mem[a][15 - (col % 16)];
  endfunction

  function automatic logic exp_border(int x, int y);
`ifdef SCANOUT_BORDER_EN
    return (x < 640 && y < 480) && !(x >= 64 && x < 576 && y >= 112 && y < 368);
`else
    return 1'b0;
`endif
  endfunction

  task automatic goto(input int t);
    while (k < t) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input int n);
    chk("rst_hsync", n, 0, hsync, 1);
    chk("rst_vsync", n, 0, vsync, 1);
    chk("rst_active", n, 0, active, 0);
    chk("rst_pixel", n, 0, pixel, 0);
    chk("rst_border", n, 0, border, 0);
    chk("rst_vblank", n, 0, vblank, 0);
    chk("rst_buf_enable", n, 0, buf_enable, 0);
    chk("rst_buf_addr", n, 0, buf_addr, 0);
  endtask

  // Walk counter positions k0..k1 checking read strobes and the delayed video outputs
  task automatic scan(input int k0, input int k1, input bit hr, input int exp_pulses, input int exp_first);
    int pulses, first, pos, x, y, ch, cv, w, n;
    bit en;
    pulses = 0;
    first = -1;
    w = hr ? 64 : 128;
    n = hr ? 8 : 4;
    goto(k0);
    while (k <= k1) begin
      pos = k - 2;
      x = pos % 800;
      y = (pos / 800) % 525;
      ch = k % 800;
      cv = (k / 800) % 525;
      en = (cv >= 112) && (cv <= 367) && (ch >= 62) && ((ch - 62) % w == 0) && ((ch - 62) / w < n);
      chk("buf_enable", ch, cv, buf_enable, en);
      if (en) chk("buf_addr", ch, cv, buf_addr, ((cv - 112) / (hr ? 4 : 8)) * n + (ch - 62) / w);
      if (buf_enable) begin
        pulses++;
        if (first < 0) first = buf_addr;
      end
      chk("pixel", x, y, pixel, exp_pix(x, y, hr));
      chk("border", x, y, border, exp_border(x, y));
      chk("active", x, y, active, (x < 640 && y < 480));
      @(negedge clk);
    end
    chk("read_count", k0 % 800, (k0 / 800) % 525, pulses, exp_pulses);
    chk("first_addr", k0 % 800, (k0 / 800) % 525, first, exp_first);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    mem[0]   = 16'hC000;
    mem[176] = 16'hC000;

    // Power-on reset, hires requested for the first frame
    repeat (3) @(negedge clk);
    check_reset_outputs(0);
    reset = 1'b0;

    // Border sample outside the window
    goto(10 * 800 + 10 + 2);
    chk("border_10_10", 10, 10, border, exp_border(10, 10));
    chk("active_10_10", 10, 10, active, 1);
    chk("pixel_10_10", 10, 10, pixel, 0);

    // Hires: word 0 = C000 lights x 64..71 on y 112..115 only
    for (int v = 112; v <= 116; v++) scan(v * 800, v * 800 + 799, 1'b1, 8, ((v - 112) / 4) * 8);

    goto(150 * 800 + 100 + 2);
    chk("border_100_150", 100, 150, border, 0);
    chk("active_100_150", 100, 150, active, 1);

    // Toggle hires at v=200: hires addressing and 4x scale continue this frame
    goto(200 * 800);
    hires = 1'b0;
    scan(200 * 800, 200 * 800 + 299, 1'b1, 4, 176);

    // Reset at h=300, v=200 for 3 clocks
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check_reset_outputs(i);
    end
    reset = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 16'h8001;
    cnt_en = 1'b1;

    // Lores frame: addresses 0..3 on rows 0, 4..7 on row 1
    scan(112 * 800, 112 * 800 + 799, 1'b0, 4, 0);
    scan(119 * 800, 119 * 800 + 799, 1'b0, 4, 0);
    scan(120 * 800, 120 * 800 + 799, 1'b0, 4, 4);

    goto(384001);
    chk("vblank_before", 0, 480, vblank, 0);
    goto(384002);
    chk("vblank_pulse", 0, 480, vblank, 1);
    goto(384003);
    chk("vblank_after", 1, 480, vblank, 0);

    goto(K_END);
    chk("hsync_low_total", 0, 0, hs_low, 493 * 96);
    chk("vsync_low_total", 0, 0, vs_low, 1600);
    chk("active_total", 0, 0, act_cnt, 307200);
    chk("vblank_count", 0, 0, vb_cnt, 1);
    chk("vblank_time", 0, 0, vb_k, 384002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/video_scanout.md
VIDEO_SCANOUT -- requirements
Module: video_scanout

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset, exactly as listed below.
REQ-002 clk  in  1  pixel clock, 25.175 MHz nominal; all logic on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 hires  in  1  1 = 128x64 mode, 0 = 64x32 mode; sampled only at frame start.
REQ-005 buf_addr  out  9  framebuffer word address on the read port.
REQ-006 buf_enable  out  1  read strobe for the framebuffer read port.
REQ-007 buf_out  in  16  framebuffer read data, valid exactly 1 clk after buf_addr/buf_enable.
REQ-008 hsync, vsync  out  1 each  active-low sync outputs.
REQ-009 active  out  1  high inside the 640x480 visible area.
REQ-010 pixel  out  1  playfield pixel value.
REQ-011 border  out  1  high for visible pixels outside the playfield window.
REQ-012 vblank  out  1  single-cycle pulse at the start of vertical blank, used as the 60 Hz tick.

Function
REQ-013 Horizontal counter h SHALL count 0..799 and wrap to 0: 640 visible, 16 front porch, 96 sync (h 656..751), 48 back porch.
REQ-014 Vertical counter v SHALL increment when h wraps and count 0..524, wrapping to 0: 480 visible, 10 front porch, 2 sync (v 490..491), 33 back porch.
REQ-015 Playfield window SHALL be x 64..575 and y 112..367 (512x256).
REQ-016 Scale SHALL be 8x8 in lores and 4x4 in hires.
REQ-017 Framebuffer layout SHALL match the blitter: 4 words/line in lores and 8 words/line in hires; address {row,word}, where row = (y-112)>>3 in lores and (y-112)>>2 in hires; bit 15 is the leftmost pixel.
REQ-018 The hires setting SHALL be latched when h=0 and v=0, and the latched value SHALL govern the whole frame.
REQ-019 The first word of each window line SHALL be read at h=62; each following word SHALL be read during display of the current word, so the word stream has no gap.
REQ-020 buf_enable SHALL be high for exactly one clk per word read, giving 4 reads/line in lores and 8 reads/line in hires, and SHALL be low outside window lines.
REQ-021 Display SHALL use a 16-bit shift register loaded from a prefetch register at each word boundary, and SHALL shift once every scale clks.
REQ-022 All outputs SHALL be registered, and hsync, vsync, active, pixel and border SHALL carry the same 2-clk latency from (h,v).
REQ-023 pixel SHALL be 0 whenever the pixel is outside the window or active is 0.
REQ-024 vblank SHALL pulse for 1 clk when the 2-clk-delayed position is h=0, v=480.
REQ-025 The read port is read-only; the scanout SHALL tolerate the blitter writing concurrently on the other port, so tearing is permitted and no lockout is applied.

Reset
REQ-026 While reset is high, h and v SHALL be 0, the latched hires SHALL be 0, the shift and prefetch registers SHALL be 0, and the pipeline SHALL be cleared.
REQ-027 While reset is high, outputs SHALL be hsync=1, vsync=1, active=0, pixel=0, border=0, vblank=0, buf_enable=0, buf_addr=0.
REQ-028 Reset asserted mid-line SHALL take effect on the next clk; after reset is released, the first frame SHALL start from h=0, v=0.

Configuration
REQ-029 With macro SCANOUT_BORDER_EN defined, border SHALL follow REQ-011.
REQ-030 Without SCANOUT_BORDER_EN, border SHALL be constant 0, and no window-compare logic SHALL exist for it.

Verification
REQ-031 Timing: release reset and run 2 frames -> hsync low for 96 clks per 800 clks, vsync low for 2 lines per 525 lines, active high for 640x480 per frame, and vblank pulses once per 420000 clks.
REQ-032 Lores pattern: every word = 16'h8001, hires=0 -> on window line y=112, pixel is high at x 64..71, 184..191, 192..199, ... and buf_enable pulses exactly 4 times per line with addresses 0..3.
REQ-033 Hires latching: hires=1, word 0 = 16'hC000, others 0 -> pixel is high at x 64..71 on y 112..115 only; buf_addr sequence is 0..7 on those lines and 8..15 on the next row.
REQ-034 Mid-frame toggle: hires toggled at v=200 -> addressing and scale are unchanged until v=0 of the next frame.
REQ-035 Border: SCANOUT_BORDER_EN defined -> border=1 at (x=10,y=10) and border=0 at (x=100,y=150); macro undefined -> border=0 throughout.
REQ-036 Reset: assert reset at h=300, v=200 for 3 clks -> outputs match REQ-027 on the next clk, and the first vblank occurs 480x800 + 2 clks after reset is released.
